// File: rtl/l1_dcache_pkg.sv
// Shared definitions for the L1 data/instruction cache.
// Holds address field widths, the controller state encoding and the
// word-select helper used to pick one 32-bit word out of a 128-bit line.
package l1_dcache_pkg;

  localparam int unsigned PADDR_W    = 30;
  localparam int unsigned OFFSET_W   = 2;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_W     = 128;
  localparam int unsigned MEM_ADDR_W = 28;
  // Bit position of a word inside a line is {word_offset, WORD_LSB_W zeros}.
  localparam int unsigned WORD_LSB_W = 5;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWriteback = 2'd1,
    StAllocate  = 2'd2
  } state_e;

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0]   line,
                                                  input logic [OFFSET_W-1:0] sel);
    return line[{sel, {WORD_LSB_W{1'b0}}} +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Storage for the direct-mapped cache: valid/dirty bits, tags and line data.
// Ports:
//   clk, rst_n          clock, async active-low reset (clears valid/dirty only)
//   idx                 line index shared by read, word write and fill
//   wr_en/wr_sel/wr_word  one-word write, sets dirty
//   fill_en/fill_tag/fill_line  full-line fill, sets valid, clears dirty
//   rd_valid/rd_dirty/rd_tag/rd_line  combinational read of line idx
module dcache_array
  import l1_dcache_pkg::*;
#(
  parameter int unsigned IDX_W = 3,
  localparam int unsigned TAG_W = PADDR_W - OFFSET_W - IDX_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_W-1:0]    idx,
  input  logic                wr_en,
  input  logic [OFFSET_W-1:0] wr_sel,
  input  logic [WORD_W-1:0]   wr_word,
  input  logic                fill_en,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [LINE_W-1:0]   fill_line,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [LINE_W-1:0]   rd_line
);

  localparam int unsigned NumLines = 2 ** IDX_W;

  logic [NumLines-1:0] valid_q;
  logic [NumLines-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NumLines];
  logic [LINE_W-1:0]   data_q [NumLines];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (wr_en) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tags and data carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_line;
    end else if (wr_en) begin
      data_q[idx][{wr_sel, {WORD_LSB_W{1'b0}}} +: WORD_W] <= wr_word;
    end
  end

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 cache controller.
// Processor side: proc_ren/proc_wen/proc_addr/proc_wdata in, proc_stall/proc_rdata out;
// hits complete in the same cycle, misses stall until the line is resident.
// Memory side: mem_read/mem_write/mem_addr/mem_wdata out, mem_rdata/mem_ready in;
// one 128-bit line per transaction, mem_ready pulses once to complete it.
// READ_ONLY=1 drops the write path entirely (instruction-cache use).
module l1_dcache
  import l1_dcache_pkg::*;
#(
  parameter int unsigned IDX_W     = 3,
  parameter bit          READ_ONLY = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  proc_ren,
  input  logic                  proc_wen,
  input  logic [PADDR_W-1:0]    proc_addr,
  input  logic [WORD_W-1:0]     proc_wdata,
  output logic                  proc_stall,
  output logic [WORD_W-1:0]     proc_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]     mem_wdata,
  input  logic [LINE_W-1:0]     mem_rdata,
  input  logic                  mem_ready
);

  localparam int unsigned TAG_W = PADDR_W - OFFSET_W - IDX_W;

  state_e                  state_q, state_d;
  logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]       mem_wdata_q, mem_wdata_d;

  logic [IDX_W-1:0]        idx;
  logic [TAG_W-1:0]        tag;
  logic [OFFSET_W-1:0]     sel;
  logic [MEM_ADDR_W-1:0]   line_addr;
  logic                    ren, wen, req, hit, victim_dirty;
  logic                    stall, wr_en, fill_en;
  logic                    rd_valid, rd_dirty;
  logic [TAG_W-1:0]        rd_tag;
  logic [LINE_W-1:0]       rd_line;

  assign sel       = proc_addr[OFFSET_W-1:0];
  assign idx       = proc_addr[IDX_W+OFFSET_W-1:OFFSET_W];
  assign tag       = proc_addr[PADDR_W-1:IDX_W+OFFSET_W];
  assign line_addr = proc_addr[PADDR_W-1:OFFSET_W];

  assign ren          = proc_ren;
  assign wen          = proc_wen & ~READ_ONLY;
  assign req          = ren | wen;
  assign hit          = rd_valid & (rd_tag == tag);
  assign victim_dirty = rd_valid & rd_dirty & ~READ_ONLY;

  dcache_array #(
    .IDX_W(IDX_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .idx      (idx),
    .wr_en    (wr_en),
    .wr_sel   (sel),
    .wr_word  (proc_wdata),
    .fill_en  (fill_en),
    .fill_tag (tag),
    .fill_line(mem_rdata),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    stall       = 1'b0;
    wr_en       = 1'b0;
    fill_en     = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          if (hit) begin
            // Write wins when both strobes are up.
            wr_en = wen;
          end else begin
            stall = 1'b1;
            if (victim_dirty) begin
              state_d     = StWriteback;
              mem_addr_d  = {rd_tag, idx};
              mem_wdata_d = rd_line;
            end else begin
              state_d    = StAllocate;
              mem_addr_d = line_addr;
            end
          end
        end
      end
      StWriteback: begin
        stall = 1'b1;
        if (mem_ready) begin
          state_d    = StAllocate;
          mem_addr_d = line_addr;
        end
      end
      StAllocate: begin
        stall = 1'b1;
        // The held request hits in IDLE on the cycle after the fill.
        if (mem_ready) begin
          fill_en = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Gating with rst_n keeps the processor side quiet while reset is held,
  // even if a request is still presented.
  assign proc_stall = rst_n & stall;
  assign proc_rdata = (rst_n && state_q == StIdle && ren && hit) ? line_word(rd_line, sel) : '0;
  assign mem_read   = (state_q == StAllocate);
  assign mem_write  = ~READ_ONLY & (state_q == StWriteback);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_l1_dcache.sv
module tb_l1_dcache;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         ren = 1'b0, wen = 1'b0, sel = 1'b0;
  logic [29:0]  addr = '0;
  logic [31:0]  wdata = '0;
  logic [127:0] mem_rdata = '0;
  logic         ready = 1'b0;

  always #5 clk = ~clk;

  logic         stall_rw, rd_rw, wr_rw, stall_ro, rd_ro, wr_ro;
  logic [31:0]  rdata_rw, rdata_ro;
  logic [27:0]  maddr_rw, maddr_ro;
  logic [127:0] mwdata_rw, mwdata_ro;

  l1_dcache #(.IDX_W(3), .READ_ONLY(1'b0)) u_rw (
    .clk(clk), .rst_n(rst_n), .proc_ren(ren & ~sel), .proc_wen(wen & ~sel),
    .proc_addr(addr), .proc_wdata(wdata), .proc_stall(stall_rw), .proc_rdata(rdata_rw),
    .mem_read(rd_rw), .mem_write(wr_rw), .mem_addr(maddr_rw), .mem_wdata(mwdata_rw),
    .mem_rdata(mem_rdata), .mem_ready(ready & ~sel)
  );

  l1_dcache #(.IDX_W(3), .READ_ONLY(1'b1)) u_ro (
    .clk(clk), .rst_n(rst_n), .proc_ren(ren & sel), .proc_wen(wen & sel),
    .proc_addr(addr), .proc_wdata(wdata), .proc_stall(stall_ro), .proc_rdata(rdata_ro),
    .mem_read(rd_ro), .mem_write(wr_ro), .mem_addr(maddr_ro), .mem_wdata(mwdata_ro),
    .mem_rdata(mem_rdata), .mem_ready(ready & sel)
  );

  // Selected instance view.
  logic         stall, m_rd, m_wr;
  logic [31:0]  rdata;
  logic [27:0]  m_addr;
  logic [127:0] m_wdata;
  assign stall   = sel ? stall_ro  : stall_rw;
  assign m_rd    = sel ? rd_ro     : rd_rw;
  assign m_wr    = sel ? wr_ro     : wr_rw;
  assign rdata   = sel ? rdata_ro  : rdata_rw;
  assign m_addr  = sel ? maddr_ro  : maddr_rw;
  assign m_wdata = sel ? mwdata_ro : mwdata_rw;

  // Reference state: backing memory, processor-visible words, resident lines.
  logic [127:0] bmem [logic [27:0]];
  logic [31:0]  gold [logic [29:0]];
  logic         rv [2][8];
  logic [27:0]  rt [2][8];
  int           lat = 0, cnt = 0;
  int           n_vec = 0, n_err = 0;
  logic [27:0]  last_wb_addr = '0, last_fill_addr = '0;
  logic [127:0] last_wb_data = '0;

  function automatic logic [31:0] init_word(input logic [29:0] wa);
    return (32'(wa) * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [127:0] line_of(input logic [27:0] la);
    logic [127:0] l;
    if (bmem.exists(la)) return bmem[la];
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = init_word({la, 2'(w)});
    return l;
  endfunction

  function automatic logic [31:0] gold_word(input logic [29:0] wa);
    logic [127:0] l;
    if (gold.exists(wa)) return gold[wa];
    l = line_of(wa[29:2]);
    return l[wa[1:0]*32 +: 32];
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare, model update and memory responder (in that order).
  always @(negedge clk) begin
    logic         req, hit_m;
    logic [2:0]   ix;
    logic [127:0] exp_line;
    int           s;
    s  = int'(sel);
    ix = addr[4:2];
    if (!rst_n) begin
      foreach (rv[i, j]) rv[i][j] = 1'b0;
      gold.delete();
      check("reset_outputs", {stall, m_rd, m_wr, rdata, m_addr}, '0);
      check("reset_wdata", m_wdata, '0);
      ready = 1'b0;
      cnt   = 0;
    end else begin
      req   = ren | (wen & ~sel);
      hit_m = rv[s][ix] && (rt[s][ix] == addr[29:2]);
      check("mem_rd_wr_exclusive", m_rd & m_wr, 0);
      check("stall", stall, req & ~hit_m);
      if (sel) check("ro_no_write", m_wr, 0);
      if (m_rd) check("fill_addr", m_addr, addr[29:2]);
      if (m_wr) begin
        check("wb_addr", {rv[s][ix], m_addr}, {1'b1, rt[s][ix]});
        for (int w = 0; w < 4; w++) exp_line[w*32 +: 32] = gold_word({m_addr, 2'(w)});
        check("wb_data", m_wdata, exp_line);
      end
      if (req && !stall && ren && !(wen && !sel)) check("rdata", rdata, gold_word(addr));
      else if (!req) check("idle_rdata", rdata, 0);
      if (!sel && wen && !stall) gold[addr] = wdata;
      // Memory responder: completes each transaction after 'lat' extra cycles.
      if (ready) cnt = 0;
      ready = 1'b0;
      if (m_rd || m_wr) begin
        if (cnt >= lat) begin
          ready = 1'b1;
          if (m_wr) begin
            bmem[m_addr] = m_wdata;
            last_wb_addr = m_addr;
            last_wb_data = m_wdata;
          end else begin
            mem_rdata      = line_of(m_addr);
            last_fill_addr = m_addr;
            rv[s][m_addr[2:0]] = 1'b1;
            rt[s][m_addr[2:0]] = m_addr;
          end
        end else begin
          cnt++;
        end
      end
    end
  end

  task automatic access(input logic s, input logic r, input logic w, input logic [29:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output int stalls);
    @(posedge clk); #1;
    sel = s; ren = r; wen = w; addr = a; wdata = d;
    stalls = 0;
    @(negedge clk);
    while (stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    check("access_timeout", stall, 0);
    rd = rdata;
    @(posedge clk); #1;
    ren = 1'b0; wen = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          st, n;
    logic [29:0] a;
    bmem[28'h4] = {32'd4, 32'd3, 32'd2, 32'd1};
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;

    // Cold read, fill returned on the fourth ALLOCATE cycle.
    lat = 3;
    access(0, 1, 0, 30'h10, 0, rd, st);
    check("cold_rdata", rd, 32'h1);
    check("cold_stalls", st, 5);
    check("cold_fill_addr", last_fill_addr, 28'h4);
    lat = 0;
    access(0, 1, 0, 30'h13, 0, rd, st);
    check("hit_rdata", rd, 32'h4);
    check("hit_stalls", st, 0);

    // Dirty eviction.
    access(0, 0, 1, 30'h11, 32'hDEADBEEF, rd, st);
    check("write_hit_stalls", st, 0);
    access(0, 1, 0, 30'h31, 0, rd, st);
    check("dirty_miss_stalls", st, 3);
    check("wb_addr_lit", last_wb_addr, 28'h4);
    check("wb_line_lit", last_wb_data, {32'd4, 32'd3, 32'hDEADBEEF, 32'd1});
    check("refill_addr_lit", last_fill_addr, 28'hC);
    check("conflict_rdata", rd, init_word(30'h31));

    // Write miss to a clean line, merge, later eviction.
    access(0, 0, 1, 30'h42, 32'h55, rd, st);
    check("write_miss_stalls", st, 2);
    access(0, 1, 0, 30'h42, 0, rd, st);
    check("merged_rdata", rd, 32'h55);
    access(0, 1, 0, 30'h82, 0, rd, st);
    check("merged_evict_stalls", st, 3);
    check("merged_wb_addr", last_wb_addr, 28'h10);
    check("merged_wb_word", last_wb_data[95:64], 32'h55);

    // Reset while a fill is outstanding.
    lat = 50;
    @(posedge clk); #1;
    sel = 0; ren = 1; addr = 30'h200;
    n = 0;
    while (!m_rd && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("alloc_reached", m_rd, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_mem_read", m_rd, 0);
    check("mid_reset_stall", stall, 0);
    ren = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    lat = 0;
    access(0, 1, 0, 30'h200, 0, rd, st);
    check("post_reset_miss_stalls", st, 2);
    access(0, 1, 0, 30'h11, 0, rd, st);
    check("post_reset_wb_word", rd, 32'hDEADBEEF);

    // Mixed traffic against the model.
    for (int i = 0; i < 200; i++) begin
      lat = $urandom_range(0, 3);
      a   = 30'h400 + 30'($urandom_range(0, 47));
      if ($urandom_range(0, 1) == 0) access(0, 1, 0, a, 0, rd, st);
      else access(0, 0, 1, a, $urandom, rd, st);
    end

    // Read-only instance: writes ignored, reads from the reference memory.
    lat = 0;
    access(1, 0, 1, 30'h1005, 32'hCAFEF00D, rd, st);
    check("ro_write_stalls", st, 0);
    access(1, 1, 0, 30'h1005, 0, rd, st);
    check("ro_cold_stalls", st, 2);
    check("ro_rdata", rd, init_word(30'h1005));
    for (int i = 0; i < 1000; i++) begin
      lat = $urandom_range(0, 3);
      a   = 30'h1000 + 30'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) access(1, 0, 1, a, $urandom, rd, st);
      else access(1, 1, 0, a, 0, rd, st);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
